// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU definitions used by the divider: FSM states and fixed constants.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_FIX,
    DIV_DONE
  } div_state_t;

  localparam int unsigned DIV_ITERS     = 32;
  localparam int unsigned DIV_CNT_W     = $clog2(DIV_ITERS);
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

  // Two's complement negate; 0x80000000 wraps onto itself.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/mips_cpu_div_if.sv
// Request/result bus between the CPU datapath (master) and the divider (slave).
interface mips_cpu_div_if;

  logic        start;
  logic        sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] r;

  modport master (output start, output sign, output a, output b,
                  input  busy,  input  done, input  r);

  modport slave  (input  start, input  sign, input  a, input  b,
                  output busy,  output done, output r);

endinterface

// File: rtl/mips_cpu_div_step.sv
// One restoring division iteration: shift in a dividend bit, trial-subtract the divisor.
module mips_cpu_div_step (
  input  logic [31:0] i_rem,
  input  logic        i_bit,
  input  logic [31:0] i_dvs,
  output logic [31:0] o_rem_c,
  output logic        o_qbit_c
);

  logic [32:0] w_shift;
  logic [32:0] w_diff;

  // Partial remainder stays below the divisor, so a 33-bit difference never overflows.
  always_comb begin
    w_shift  = {i_rem, i_bit};
    w_diff   = w_shift - {1'b0, i_dvs};
    o_qbit_c = ~w_diff[32];
    o_rem_c  = w_diff[32] ? w_shift[31:0] : w_diff[31:0];
  end

endmodule

// File: rtl/mips_cpu_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result packed {remainder, quotient}.
module mips_cpu_div
  import mips_cpu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  mips_cpu_div_if.slave bus
);

  div_state_t            r_state;
  div_state_t            w_state_nxt;
  logic [DIV_CNT_W-1:0]  r_cnt;
  logic [31:0]           r_rem;
  logic [31:0]           r_quo;
  logic [31:0]           r_dvs;
  logic                  r_qsign;
  logic                  r_rsign;
  logic                  r_dz;
  logic                  r_busy;
  logic                  r_done;
  logic [63:0]           r_r;

  logic [31:0]           w_rem_nxt;
  logic                  w_qbit;
  logic [31:0]           w_quo_fix;
  logic [31:0]           w_rem_fix;

  // Dividend magnitude is shifted out of r_quo MSB-first while quotient bits enter at the LSB.
  mips_cpu_div_step u_step (
    .i_rem    (r_rem),
    .i_bit    (r_quo[31]),
    .i_dvs    (r_dvs),
    .o_rem_c  (w_rem_nxt),
    .o_qbit_c (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= DIV_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      DIV_IDLE: if (bus.start) w_state_nxt = DIV_RUN;
      DIV_RUN:  if (r_cnt == '0) w_state_nxt = DIV_FIX;
      DIV_FIX:  w_state_nxt = DIV_DONE;
      DIV_DONE: w_state_nxt = DIV_IDLE;
      default:  w_state_nxt = DIV_IDLE;
    endcase
  end

  // Divide-by-zero forces the quotient; the remainder path already reproduces the dividend.
  assign w_quo_fix = r_dz    ? DIV_BY_ZERO_Q : (r_qsign ? neg32(r_quo) : r_quo);
  assign w_rem_fix = r_rsign ? neg32(r_rem) : r_rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
      r_dz    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_r     <= '0;
    end else begin
      r_busy <= (w_state_nxt != DIV_IDLE);
      r_done <= (w_state_nxt == DIV_DONE);
      unique case (r_state)
        DIV_IDLE: begin
          if (bus.start) begin
            r_quo   <= (bus.sign && bus.a[31]) ? neg32(bus.a) : bus.a;
            r_dvs   <= (bus.sign && bus.b[31]) ? neg32(bus.b) : bus.b;
            r_qsign <= bus.sign & (bus.a[31] ^ bus.b[31]);
            r_rsign <= bus.sign & bus.a[31];
            r_dz    <= (bus.b == '0);
            r_rem   <= '0;
            r_cnt   <= DIV_CNT_W'(DIV_ITERS - 1);
          end
        end
        DIV_RUN: begin
          r_rem <= w_rem_nxt;
          r_quo <= {r_quo[30:0], w_qbit};
          if (r_cnt != '0) r_cnt <= r_cnt - DIV_CNT_W'(1);
        end
        DIV_FIX: r_r <= {w_rem_fix, w_quo_fix};
        default: ;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.r    = r_r;

endmodule

// File: tb/tb_mips_cpu_div.sv
// Directed and random checks of mips_cpu_div against an arithmetic reference model.
module tb_mips_cpu_div;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   n;
  int   pulses;
  logic [63:0] prev_r;
  logic [31:0] ra;
  logic [31:0] rb;
  logic        rs;

  mips_cpu_div_if dif ();

  mips_cpu_div dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division; 64-bit signed math sidesteps the -2^31/-1 overflow.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa;
    longint sb;
    logic [31:0] q;
    logic [31:0] rm;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      rm = 32'(sa % sb);
    end else begin
      q  = a / b;
      rm = a % b;
    end
    return {rm, q};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Edges from start (E0) to the first done; gives up after 40.
  task automatic wait_done(output int edges);
    edges = 0;
    while (dif.done !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    dif.start = 1'b1; dif.a = a; dif.b = b; dif.sign = s;
    @(posedge clk); #1;
    dif.start = 1'b0; dif.a = $urandom; dif.b = $urandom; dif.sign = 1'($urandom);
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
    logic [63:0] exp;
    int e;
    exp = model(a, b, s);
    issue(a, b, s);
    check({tag, " busy_after_start"}, 64'(dif.busy), 64'd1);
    check({tag, " r_held_on_start"}, dif.r, prev_r);
    wait_done(e);
    check({tag, " latency"}, 64'(e), 64'd33);
    check({tag, " result"}, dif.r, exp);
    @(posedge clk); #1;
    check({tag, " idle_after"}, 64'({dif.busy, dif.done}), 64'd0);
    prev_r = exp;
  endtask

  initial begin
    total = 0; bad = 0; prev_r = '0;
    dif.start = 1'b0; dif.sign = 1'b0; dif.a = '0; dif.b = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(dif.busy), 64'd0);
    check("reset_done", 64'(dif.done), 64'd0);
    check("reset_r", dif.r, 64'd0);
    @(negedge clk); reset = 1'b0;

    run_div(32'd100, 32'd7, 1'b0, "u100_7");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "s-7_2");
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, "s7_-2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_ovf");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "u_big");
    run_div(32'h1234_5678, 32'd0, 1'b0, "u_dz");
    run_div(32'h1234_5678, 32'd0, 1'b1, "s_dz");
    run_div(32'hEDCB_A988, 32'd0, 1'b1, "s_dz_neg");
    run_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, "s-7_-2");

    // Start while busy is dropped without queuing.
    issue(32'd5, 32'd1, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    @(negedge clk);
    dif.start = 1'b1; dif.a = 32'd9; dif.b = 32'd3; dif.sign = 1'b0;
    @(posedge clk); #1;
    dif.start = 1'b0;
    wait_done(n);
    check("busy_start latency", 64'(n + 10), 64'd33);
    check("busy_start result", dif.r, {32'd0, 32'd5});
    pulses = 0;
    repeat (40) begin @(posedge clk); #1; if (dif.done) pulses++; end
    check("busy_start no_queue", 64'(pulses), 64'd0);
    prev_r = {32'd0, 32'd5};

    // Reset mid-division aborts without a done pulse.
    issue(32'd100, 32'd7, 1'b0);
    repeat (19) begin @(posedge clk); #1; end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 64'(dif.busy), 64'd0);
    check("abort_r", dif.r, 64'd0);
    @(negedge clk); reset = 1'b0;
    pulses = 0;
    repeat (40) begin @(posedge clk); #1; if (dif.done || dif.busy) pulses++; end
    check("abort_quiet", 64'(pulses), 64'd0);
    prev_r = '0;
    run_div(32'd1000, 32'd33, 1'b0, "after_reset");

    // Random operands, with small divisors and zero mixed in.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom);
      if (i % 4 == 1) rb = 32'($urandom_range(1, 15));
      if (i % 4 == 2 && rs) rb = -32'($urandom_range(1, 15));
      if (i == 7) rb = 32'd0;
      run_div(ra, rb, rs, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
